// File: rtl/l1i_cache.sv
// Direct-mapped read-only L1 instruction cache, 32-byte lines refilled as four 64-bit beats.
// One outstanding fetch; hits answer in the cycle after the request, misses after a full line refill.
module l1i_cache #(
    parameter int unsigned LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] im_req_addr,
    input  logic        im_req_valid,
    output logic [63:0] im_resp_rdata,
    output logic        im_resp_valid,
    input  logic        inv,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    input  logic [63:0] mem_resp_rdata,
    input  logic        mem_resp_valid
);
    localparam int unsigned IDXW = $clog2(LINES);
    localparam int unsigned TAGW = 64 - 5 - IDXW;

    typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_DATA, RESP} state_t;
    state_t state;

    logic [63:0]      data_mem [LINES*4];
    logic [TAGW-1:0]  tag_mem  [LINES];
    logic [LINES-1:0] valid;

    logic [63:0]     addr_q;
    logic [63:0]     data_rd;
    logic [63:0]     resp_q;
    logic [TAGW-1:0] tag_rd;
    logic            lookup;
    logic            inv_seen;
    logic [1:0]      cnt;

    logic [IDXW-1:0] req_idx;
    logic [IDXW-1:0] idx_q;
    logic [TAGW-1:0] tag_q;
    logic            hit;
    logic            accept;
    logic            beat;
    logic            last_beat;
    logic            unused_addr_bits;

    assign req_idx   = im_req_addr[5 +: IDXW];
    assign idx_q     = addr_q[5 +: IDXW];
    assign tag_q     = addr_q[63 -: TAGW];
    assign unused_addr_bits = ^{im_req_addr[2:0], addr_q[2:0]};

    // lookup marks the compare cycle; the arrays were read on the previous edge
    assign hit       = lookup && valid[idx_q] && (tag_rd == tag_q);
    assign accept    = im_req_valid &&
                       (((state == IDLE) && (!lookup || hit)) || (state == RESP));
    assign beat      = (state == REFILL_DATA) && mem_resp_valid;
    assign last_beat = beat && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (beat)
            data_mem[{idx_q, cnt}] <= mem_resp_rdata;
        if (last_beat)
            tag_mem[idx_q] <= tag_q;
        if (accept) begin
            data_rd <= data_mem[{req_idx, im_req_addr[4:3]}];
            tag_rd  <= tag_mem[req_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            valid        <= '0;
            lookup       <= 1'b0;
            inv_seen     <= 1'b0;
            cnt          <= '0;
            addr_q       <= '0;
            resp_q       <= '0;
            mem_req_addr <= '0;
        end else begin
            lookup <= accept;
            if (accept)
                addr_q <= im_req_addr;

            // inv wins over a same-cycle fill so the refilled line stays invalid
            if (inv)
                valid <= '0;
            else if (last_beat && !inv_seen)
                valid[idx_q] <= 1'b1;

            case (state)
                IDLE: begin
                    if (lookup && !hit) begin
                        state        <= REFILL_REQ;
                        mem_req_addr <= {addr_q[63:5], 5'b0};
                        inv_seen     <= 1'b0;
                    end
                end
                REFILL_REQ: begin
                    if (inv)
                        inv_seen <= 1'b1;
                    if (mem_req_ready) begin
                        state <= REFILL_DATA;
                        cnt   <= '0;
                    end
                end
                REFILL_DATA: begin
                    if (inv)
                        inv_seen <= 1'b1;
                    if (mem_resp_valid) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == addr_q[4:3])
                            resp_q <= mem_resp_rdata;
                        if (cnt == 2'd3)
                            state <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req_valid = (state == REFILL_REQ);
    assign im_resp_valid = hit || (state == RESP);

    always_comb begin
        im_resp_rdata = '0;
        if (state == RESP)
            im_resp_rdata = resp_q;
        else if (hit)
            im_resp_rdata = data_rd;
    end
endmodule

// File: tb/tb_l1i_cache.sv
// Directed bench for l1i_cache: a hit-vector table plus hand-sequenced refills covering
// backpressure, conflict eviction, invalidation races and reset mid-refill.
module tb_l1i_cache;
    logic        clk;
    logic        rst;
    logic [63:0] im_req_addr;
    logic        im_req_valid;
    logic [63:0] im_resp_rdata;
    logic        im_resp_valid;
    logic        inv;
    logic [63:0] mem_req_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_resp_rdata;
    logic        mem_resp_valid;

    int total = 0;
    int bad   = 0;

    localparam int INV_AT_REQ = 8;
    localparam int NO_INV     = 9;

    l1i_cache #(.LINES(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .im_req_addr    (im_req_addr),
        .im_req_valid   (im_req_valid),
        .im_resp_rdata  (im_resp_rdata),
        .im_resp_valid  (im_resp_valid),
        .inv            (inv),
        .mem_req_addr   (mem_req_addr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_valid (mem_resp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // A request is legal unless a fetch is outstanding and no response is visible this cycle.
    logic pend;
    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (im_req_valid) begin
                total++;
                if (pend && !im_resp_valid) begin
                    bad++;
                    $display("FAIL proto: got request while busy want no request (addr %h)", im_req_addr);
                end
            end
            if (im_req_valid)
                pend <= 1'b1;
            else if (im_resp_valid)
                pend <= 1'b0;
        end
    end

    typedef struct {
        logic [63:0] addr;
        logic [63:0] exp;
    } hit_vec_t;
    hit_vec_t hits[12];

    // Issues requests lo..hi back to back; each must hit one cycle later.
    task automatic run_hits(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            im_req_valid = 1'b1;
            im_req_addr  = hits[i].addr;
            @(negedge clk);
            check($sformatf("hit_valid[%0d]", i), {63'b0, im_resp_valid}, 64'd1);
            check($sformatf("hit_data[%0d]", i), im_resp_rdata, hits[i].exp);
            check($sformatf("hit_nomem[%0d]", i), {63'b0, mem_req_valid}, 64'd0);
        end
        im_req_valid = 1'b0;
        @(negedge clk);
        check("hit_quiet", {63'b0, im_resp_valid}, 64'd0);
    endtask

    // Full miss: memory returns base+0..base+3; ready after rdy_dly cycles, gap idle cycles before each beat.
    task automatic miss_seq(input logic [63:0] a, input logic [63:0] base,
                            input int rdy_dly, input int gap, input int inv_beat);
        logic [63:0] line;
        line = {a[63:5], 5'b0};
        im_req_valid = 1'b1;
        im_req_addr  = a;
        inv          = (inv_beat == INV_AT_REQ);
        @(negedge clk);
        im_req_valid = 1'b0;
        inv          = 1'b0;
        check("miss_cmp_valid", {63'b0, im_resp_valid}, 64'd0);
        check("miss_cmp_mreq", {63'b0, mem_req_valid}, 64'd0);
        @(negedge clk);
        for (int i = 0; i < rdy_dly; i++) begin
            check("wait_mreq_valid", {63'b0, mem_req_valid}, 64'd1);
            check("wait_mreq_addr", mem_req_addr, line);
            @(negedge clk);
        end
        check("mreq_valid", {63'b0, mem_req_valid}, 64'd1);
        check("mreq_addr", mem_req_addr, line);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("mreq_dropped", {63'b0, mem_req_valid}, 64'd0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                check("gap_no_resp", {63'b0, im_resp_valid}, 64'd0);
                @(negedge clk);
            end
            mem_resp_valid = 1'b1;
            mem_resp_rdata = base + 64'(b);
            inv            = (inv_beat == b);
            @(negedge clk);
            mem_resp_valid = 1'b0;
            inv            = 1'b0;
        end
        check("miss_resp_valid", {63'b0, im_resp_valid}, 64'd1);
        check("miss_resp_data", im_resp_rdata, base + {62'b0, a[4:3]});
        @(negedge clk);
        check("miss_resp_once", {63'b0, im_resp_valid}, 64'd0);
    endtask

    initial begin
        hits[0]  = '{64'h1000_0008, 64'hA1};
        hits[1]  = '{64'h1000_0010, 64'hA2};
        hits[2]  = '{64'h1000_0018, 64'hA3};
        hits[3]  = '{64'h1000_0000, 64'hA0};
        hits[4]  = '{64'h1000_0024, 64'hB0};
        hits[5]  = '{64'h1000_000C, 64'hA1};
        hits[6]  = '{64'h1000_003F, 64'hB3};
        hits[7]  = '{64'h1000_0010, 64'hA2};
        hits[8]  = '{64'h1000_0818, 64'hC3};
        hits[9]  = '{64'h1000_0028, 64'hB1};
        hits[10] = '{64'h1000_0070, 64'hE6};
        hits[11] = '{64'h1000_0098, 64'hF3};

        rst            = 1'b1;
        im_req_addr    = '0;
        im_req_valid   = 1'b0;
        inv            = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_rdata = '0;
        mem_resp_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_resp_valid", {63'b0, im_resp_valid}, 64'd0);
        check("rst_resp_data", im_resp_rdata, 64'd0);
        check("rst_mreq_valid", {63'b0, mem_req_valid}, 64'd0);
        check("rst_mreq_addr", mem_req_addr, 64'd0);
        @(negedge clk);

        miss_seq(64'h1000_0000, 64'hA0, 0, 0, NO_INV);
        run_hits(0, 2);
        miss_seq(64'h1000_0030, 64'hB0, 5, 2, NO_INV);
        run_hits(3, 7);

        miss_seq(64'h1000_0800, 64'hC0, 0, 0, NO_INV);
        run_hits(8, 9);
        miss_seq(64'h1000_0000, 64'hD0, 1, 0, NO_INV);

        miss_seq(64'h1000_0060, 64'hE0, 0, 0, 1);
        miss_seq(64'h1000_0068, 64'hE4, 0, 0, NO_INV);
        run_hits(10, 10);

        miss_seq(64'h1000_0080, 64'hF0, 0, 0, 3);
        miss_seq(64'h1000_0080, 64'hF0, 0, 0, NO_INV);
        run_hits(11, 11);
        miss_seq(64'h1000_0088, 64'h70, 0, 0, INV_AT_REQ);

        im_req_valid = 1'b1;
        im_req_addr  = 64'h1000_0040;
        @(negedge clk);
        im_req_valid = 1'b0;
        @(negedge clk);
        check("rstmid_mreq", {63'b0, mem_req_valid}, 64'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h30;
        @(negedge clk);
        mem_resp_rdata = 64'h31;
        @(negedge clk);
        mem_resp_rdata = 64'h32;
        rst            = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        mem_resp_valid = 1'b0;
        check("rstmid_mreq_drop", {63'b0, mem_req_valid}, 64'd0);
        check("rstmid_no_resp", {63'b0, im_resp_valid}, 64'd0);
        @(negedge clk);
        check("rstmid_still_quiet", {63'b0, im_resp_valid}, 64'd0);
        miss_seq(64'h1000_0040, 64'h50, 0, 0, NO_INV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/l1i_cache.md
# l1i_cache

Direct-mapped, read-only L1 instruction cache acting as the responder on the instruction-memory interface driven by the fetch pipeline. It returns the aligned 64-bit doubleword for each fetch request: one cycle after the request on a hit, or after a 4-beat line refill from a backing 64-bit memory bus on a miss. It holds at most one outstanding fetch and supports whole-cache invalidation (fence.i).

## Interface
- LINES, 64: number of lines; power of two; IDXW = log2(LINES).
- Line size is fixed at 32 B (4 × 64-bit beats); offset = addr[4:0], index = addr[5+IDXW-1:5], tag = addr[63:5+IDXW].
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- im_req_addr  in  64  fetch byte address; addr[2:0] ignored.
- im_req_valid  in  1  single-cycle fetch request.
- im_resp_rdata  out  64  doubleword at im_req_addr & ~7.
- im_resp_valid  out  1  one-cycle response strobe, exactly one per accepted request.
- inv  in  1  invalidate all lines (pulse).
- mem_req_addr  out  64  line-aligned refill address (bits [4:0] = 0).
- mem_req_valid  out  1  refill request; held until mem_req_ready.
- mem_req_ready  in  1  backing memory accepts request.
- mem_resp_rdata  in  64  refill beat data, ascending beat order 0..3.
- mem_resp_valid  in  1  refill beat strobe; no backpressure.

## Operation
- Storage: data array LINES×4×64 (synchronous read), tag array LINES×TAGW (synchronous read), valid bits as a LINES-bit flop vector.
- States: IDLE, REFILL_REQ, REFILL_DATA, RESP.
- IDLE: on im_req_valid, latch addr and read the arrays at index/beat addr[4:3]. Next cycle (compare cycle): hit = valid[idx] && tag match → im_resp_valid=1, rdata from the data array, stay in IDLE. Miss → im_resp_valid=0, go to REFILL_REQ.
- REFILL_REQ: mem_req_valid=1, mem_req_addr = {latched addr[63:5], 5'b0}. On mem_req_ready, go to REFILL_DATA with beat counter = 0.
- REFILL_DATA: each mem_resp_valid writes the beat to data[idx][cnt]; when cnt equals latched addr[4:3], also capture the beat into the response register. On beat 3, write the tag, set valid[idx] (unless inv was seen during the refill), and go to RESP.
- RESP: im_resp_valid=1, rdata = response register, then go to IDLE.
- Request acceptance: legal only in IDLE or RESP, or in a hit compare cycle (back-to-back hits at one per cycle). A request in the RESP cycle is treated exactly as a request in IDLE. Requests in any other cycle are a protocol violation: they are ignored and flagged by a bench assertion.
- Miss replaces the indexed line unconditionally; there is no dirty state.
- inv: clears all valid bits at the end of the cycle it is high. A lookup whose compare cycle is after the inv cycle sees the lines invalid; a request issued in the same cycle as inv therefore misses. inv during REFILL_REQ/REFILL_DATA: the refill completes and the response is delivered, but the line is left invalid.
- inv simultaneous with the final refill beat: the line is left invalid.

## Timing
- Reset values: state IDLE, all valid bits 0, im_resp_valid 0, mem_req_valid 0, im_resp_rdata 0, mem_req_addr 0, beat counter 0.
- Hit latency: request in cycle N → im_resp_valid in N+1; sustained throughput 1 fetch/cycle.
- Miss: compare cycle N+1 (im_resp_valid=0); mem_req_valid first high in N+2. With ready in N+2 and four consecutive beats in N+3..N+6, im_resp_valid is high in N+7.
- mem_req_valid and mem_req_addr are stable while waiting for ready.
- Reset mid-refill: return to IDLE next cycle, mem_req_valid drops. Backing memory shares rst, so no stale beats arrive after reset.
- im_resp_valid is never high in two consecutive cycles without an accepted request in the first of them.

## Test plan
- Cold miss: after reset, request 0x10000000 with memory returning beats 0xA0..0xA3 → mem_req_addr=0x10000000; im_resp_rdata=0xA0 in N+7 with ready and beats immediate.
- Back-to-back hits: requests 0x10000008, 0x10000010, 0x10000018 in consecutive cycles → responses 0xA1, 0xA2, 0xA3 one cycle later each; no mem_req_valid.
- Conflict eviction (LINES=64): request 0x10000800 (same index, new tag) → refill at 0x10000800; then 0x10000000 misses again.
- Backpressure: mem_req_ready held low 5 cycles, beats spaced with gaps → mem_req_addr stable, response appears exactly 1 cycle after beat 3.
- inv: pulse inv during a refill → response still returned; a repeat request misses. Pulse inv with a hit-line request in the same cycle → miss.
- Reset at beat 2 of a refill → mem_req_valid=0 and im_resp_valid=0 next cycle; a following request to the same address misses.
